// File: rtl/cam_capture_rgb565_444.sv
// rtl/cam_capture_rgb565_444.sv - OV7670 QQVGA RGB565 capture, repacked to RGB444 frame-buffer writes
//
// Ports:
//   clk             camera pixel clock, all logic on the rising edge
//   rst             synchronous reset, active-low
//   CAM_vsync       frame sync, high during vertical blanking
//   CAM_href        line valid, high while bytes are valid
//   CAM_px_data     camera data byte (two bytes per RGB565 pixel)
//   DP_RAM_regW     one-cycle write strobe per stored pixel
//   DP_RAM_addr_in  linear write address 0..WC*WR-1
//   DP_RAM_data_in  pixel {R[3:0],G[3:0],B[3:0]}
//   frame_done      one-cycle pulse when VSYNC rises at the end of a captured frame
//   overflow        sticky, more than WC*WR pixels arrived in this frame
//   sync_err        sticky, HREF fell after an odd number of bytes
//
// Optional build macro CAM_CAPTURE_TEST_PATTERN_EN replaces camera data with
// eight vertical colour bars; timing, addresses and flags are unchanged.
module cam_capture_rgb565_444 #(
    parameter int AW = 15,
    parameter int DW = 12,
    parameter int WC = 160,
    parameter int WR = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    output logic          DP_RAM_regW,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          frame_done,
    output logic          overflow,
    output logic          sync_err
);

    // Address WC*WR is the reader's out-of-window pixel, so the counter stops there.
    localparam logic [AW-1:0] PIX_MAX = AW'(WC * WR);

    typedef enum logic {S_IDLE, S_CAPTURE} state_t;

    state_t        state_q, state_d;
    logic          vsync_q, vsync_d;
    logic          phase_q, phase_d;
    logic [7:0]    byte_hi_q, byte_hi_d;
    logic [AW-1:0] pix_cnt_q, pix_cnt_d;
    logic          regw_q, regw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;
    logic          sync_err_q, sync_err_d;

    logic          vs_fall;
    logic          vs_rise;
    logic [11:0]   pixel;

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    // Bars are 20 columns wide; column is the position within the current line.
    always_comb begin
        pixel = 12'h000;
        case ((int'(pix_cnt_q) % WC) / 20)
            0:       pixel = 12'hFFF;
            1:       pixel = 12'hFF0;
            2:       pixel = 12'h0FF;
            3:       pixel = 12'h0F0;
            4:       pixel = 12'hF0F;
            5:       pixel = 12'hF00;
            6:       pixel = 12'h00F;
            default: pixel = 12'h000;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{byte_hi_q, CAM_px_data};
`else
    // RGB565 {RRRRRGGG,GGGBBBBB} -> top four bits of each channel.
    assign pixel = {byte_hi_q[7:4], byte_hi_q[2:0], CAM_px_data[7], CAM_px_data[4:1]};

    logic unused_bits;
    assign unused_bits = ^{byte_hi_q[3], CAM_px_data[6:5], CAM_px_data[0]};
`endif

    assign vs_fall = vsync_q & ~CAM_vsync;
    assign vs_rise = ~vsync_q & CAM_vsync;

    always_comb begin
        state_d      = state_q;
        vsync_d      = CAM_vsync;
        phase_d      = phase_q;
        byte_hi_d    = byte_hi_q;
        pix_cnt_d    = pix_cnt_q;
        regw_d       = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        sync_err_d   = sync_err_q;

        case (state_q)
            S_IDLE: begin
                if (vs_fall) begin
                    state_d    = S_CAPTURE;
                    pix_cnt_d  = '0;
                    phase_d    = 1'b0;
                    overflow_d = 1'b0;
                    sync_err_d = 1'b0;
                    // A byte arriving on the frame-start edge is the first high byte.
                    if (CAM_href) begin
                        byte_hi_d = CAM_px_data;
                        phase_d   = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (CAM_href) begin
                    if (!phase_q) begin
                        byte_hi_d = CAM_px_data;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (pix_cnt_q < PIX_MAX) begin
                            regw_d    = 1'b1;
                            addr_d    = pix_cnt_q;
                            data_d    = DW'(pixel);
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end else begin
                    if (phase_q) begin
                        sync_err_d = 1'b1;
                    end
                    phase_d = 1'b0;
                end
                // End of frame is evaluated after any pixel completed on this edge.
                if (vs_rise) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            phase_q      <= 1'b0;
            byte_hi_q    <= '0;
            pix_cnt_q    <= '0;
            regw_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            phase_q      <= phase_d;
            byte_hi_q    <= byte_hi_d;
            pix_cnt_q    <= pix_cnt_d;
            regw_q       <= regw_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign DP_RAM_regW    = regw_q;
    assign DP_RAM_addr_in = addr_q;
    assign DP_RAM_data_in = data_q;
    assign frame_done     = frame_done_q;
    assign overflow       = overflow_q;
    assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_cam_capture_rgb565_444.sv
// tb/tb_cam_capture_rgb565_444.sv - directed self-checking bench for cam_capture_rgb565_444
module tb_cam_capture_rgb565_444;

    logic        clk = 1'b0;
    logic        rst;
    logic        CAM_vsync;
    logic        CAM_href;
    logic [7:0]  CAM_px_data;
    logic        DP_RAM_regW;
    logic [14:0] DP_RAM_addr_in;
    logic [11:0] DP_RAM_data_in;
    logic        frame_done;
    logic        overflow;
    logic        sync_err;

    always #5 clk = ~clk;

    cam_capture_rgb565_444 dut (
        .clk            (clk),
        .rst            (rst),
        .CAM_vsync      (CAM_vsync),
        .CAM_href       (CAM_href),
        .CAM_px_data    (CAM_px_data),
        .DP_RAM_regW    (DP_RAM_regW),
        .DP_RAM_addr_in (DP_RAM_addr_in),
        .DP_RAM_data_in (DP_RAM_data_in),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .sync_err       (sync_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int strobes, addr_err, data_err, fd_cnt, next_addr, max_addr;
    bit bulk_on = 1'b0;

    function automatic logic [11:0] exp_pix(input int col, input logic [11:0] normal);
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
        case (col / 20)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
`else
        if (col < 0) return 12'h000;
        return normal;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        strobes   = 0;
        addr_err  = 0;
        data_err  = 0;
        fd_cnt    = 0;
        next_addr = 0;
        max_addr  = -1;
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (DP_RAM_regW === 1'b1) begin
            strobes++;
            if (int'(DP_RAM_addr_in) > max_addr) max_addr = int'(DP_RAM_addr_in);
            if (bulk_on) begin
                if (DP_RAM_addr_in !== 15'(next_addr)) addr_err++;
                if (DP_RAM_data_in !== exp_pix(next_addr % 160, 12'hF0F)) data_err++;
                next_addr++;
            end
        end
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        CAM_href    = 1'b1;
        CAM_px_data = b;
        tick();
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(8'hF8);
            send_byte(8'h1F);
        end
    endtask

    task automatic blank();
        CAM_href = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame_start();
        CAM_href  = 1'b0;
        CAM_vsync = 1'b1;
        tick();
        tick();
        CAM_vsync = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; CAM_vsync = 1'b0; CAM_href = 1'b0; CAM_px_data = 8'h00;
        clear_mon();
        repeat (3) tick();
        chk("rst_regW",       32'(DP_RAM_regW),    32'h0);
        chk("rst_addr",       32'(DP_RAM_addr_in), 32'h0);
        chk("rst_data",       32'(DP_RAM_data_in), 32'h0);
        chk("rst_frame_done", 32'(frame_done),     32'h0);
        chk("rst_overflow",   32'(overflow),       32'h0);
        chk("rst_sync_err",   32'(sync_err),       32'h0);

        // Leave reset in the middle of a frame: nothing is written before a VSYNC fall.
        rst = 1'b1;
        repeat (2) begin send_pixels(160); blank(); end
        chk("no_strobe_before_sof", 32'(strobes), 32'd0);

        // Full frame plus one extra line: 19200 writes, then overflow.
        frame_start();
        clear_mon();
        bulk_on = 1'b1;
        repeat (120) begin send_pixels(160); blank(); end
        chk("full_frame_strobes", 32'(strobes),  32'd19200);
        chk("full_frame_no_ovf",  32'(overflow), 32'h0);
        send_pixels(160); blank();
        chk("ovf_line_strobes",   32'(strobes),  32'd19200);
        chk("ovf_set",            32'(overflow), 32'h1);
        chk("bulk_addr_errors",   32'(addr_err), 32'd0);
        chk("bulk_data_errors",   32'(data_err), 32'd0);
        chk("max_addr",           32'(max_addr), 32'd19199);
        bulk_on = 1'b0;
        CAM_vsync = 1'b1;
        tick();
        chk("frame_done_pulse",   32'(frame_done), 32'h1);
        tick();
        chk("frame_done_one_cyc", 32'(frame_done), 32'h0);
        chk("frame_done_count",   32'(fd_cnt),     32'd1);

        // Directed pixels, odd-length line, pixel completing on the VSYNC rise.
        CAM_vsync = 1'b0;
        tick();
        clear_mon();
        chk("sof_clears_ovf", 32'(overflow), 32'h0);
        send_byte(8'hAB);
        chk("lat_phase0_no_w", 32'(DP_RAM_regW), 32'h0);
        send_byte(8'hCD);
        chk("p0_regW", 32'(DP_RAM_regW),    32'h1);
        chk("p0_addr", 32'(DP_RAM_addr_in), 32'd0);
        chk("p0_data", 32'(DP_RAM_data_in), 32'(exp_pix(0, 12'hA76)));
        send_byte(8'h12);
        chk("strobe_one_cycle", 32'(DP_RAM_regW),    32'h0);
        chk("addr_held",        32'(DP_RAM_addr_in), 32'd0);
        chk("data_held",        32'(DP_RAM_data_in), 32'(exp_pix(0, 12'hA76)));
        send_byte(8'h34);
        chk("p1_addr", 32'(DP_RAM_addr_in), 32'd1);
        chk("p1_data", 32'(DP_RAM_data_in), 32'(exp_pix(1, 12'h14A)));
        send_byte(8'h5E);
        send_byte(8'h81);
        chk("p2_addr", 32'(DP_RAM_addr_in), 32'd2);
        chk("p2_data", 32'(DP_RAM_data_in), 32'(exp_pix(2, 12'h5D0)));
        send_pixels(157);
        send_byte(8'h77);
        CAM_href = 1'b0;
        tick();
        chk("odd_line_sync_err", 32'(sync_err), 32'h1);
        chk("odd_line_strobes",  32'(strobes),  32'd160);
        chk("odd_line_last",     32'(DP_RAM_addr_in), 32'd159);
        blank();
        send_byte(8'h12);
        chk("next_line_phase0", 32'(DP_RAM_regW), 32'h0);
        send_byte(8'h34);
        chk("next_line_addr", 32'(DP_RAM_addr_in), 32'd160);
        chk("next_line_data", 32'(DP_RAM_data_in), 32'(exp_pix(0, 12'h14A)));
        send_byte(8'hAB);
        CAM_px_data = 8'hCD;
        CAM_vsync   = 1'b1;
        tick();
        chk("eof_pixel_regW", 32'(DP_RAM_regW),    32'h1);
        chk("eof_pixel_addr", 32'(DP_RAM_addr_in), 32'd161);
        chk("eof_pixel_data", 32'(DP_RAM_data_in), 32'(exp_pix(1, 12'hA76)));
        chk("eof_frame_done", 32'(frame_done),     32'h1);
        CAM_href = 1'b0;
        tick();
        chk("eof_regW_low",      32'(DP_RAM_regW), 32'h0);
        chk("sync_err_sticky",   32'(sync_err),    32'h1);

        // Frame start coinciding with the first byte, then reset at pixel 5000.
        CAM_vsync   = 1'b0;
        CAM_href    = 1'b1;
        CAM_px_data = 8'h5E;
        tick();
        chk("sof_clears_sync_err", 32'(sync_err), 32'h0);
        CAM_px_data = 8'h81;
        tick();
        chk("sof_byte_regW", 32'(DP_RAM_regW),    32'h1);
        chk("sof_byte_addr", 32'(DP_RAM_addr_in), 32'd0);
        chk("sof_byte_data", 32'(DP_RAM_data_in), 32'(exp_pix(0, 12'h5D0)));
        send_pixels(159);
        blank();
        repeat (30) begin send_pixels(160); blank(); end
        send_pixels(40);
        chk("pre_reset_addr", 32'(DP_RAM_addr_in), 32'd4999);
        send_byte(8'hF8);
        CAM_px_data = 8'h1F;
        rst = 1'b0;
        tick();
        chk("midrst_regW",       32'(DP_RAM_regW),    32'h0);
        chk("midrst_addr",       32'(DP_RAM_addr_in), 32'h0);
        chk("midrst_data",       32'(DP_RAM_data_in), 32'h0);
        chk("midrst_frame_done", 32'(frame_done),     32'h0);
        rst = 1'b1;
        CAM_href = 1'b0;
        tick();
        clear_mon();
        repeat (2) begin send_pixels(160); blank(); end
        chk("post_rst_no_strobe", 32'(strobes), 32'd0);
        frame_start();
        send_byte(8'h12);
        send_byte(8'h34);
        chk("resume_regW", 32'(DP_RAM_regW),    32'h1);
        chk("resume_addr", 32'(DP_RAM_addr_in), 32'd0);
        chk("resume_data", 32'(DP_RAM_data_in), 32'(exp_pix(0, 12'h14A)));
        CAM_href = 1'b0;
        tick();
        CAM_vsync = 1'b1;
        tick();
        chk("resume_frame_done", 32'(frame_done), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
